// File: rtl/multi_test_clk.sv
// Multi-channel programmable test clock generator with per-channel offset,
// duty, drift injection and finite burst mode.
package clks_alot_p;
    localparam int RATE_COUNTER_WIDTH = 8;
endpackage

module multi_test_clk #(
    parameter int CHANNELS    = 2,
    parameter int RATE_WIDTH  = clks_alot_p::RATE_COUNTER_WIDTH,
    parameter int BURST_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           async_rst_n,
    input  logic                           clk_en,
    input  logic [CHANNELS-1:0]            init_i,
    input  logic [CHANNELS-1:0]            starting_polarity_i,
    input  logic [CHANNELS-1:0]            generation_en_i,
    input  logic [CHANNELS*RATE_WIDTH-1:0] high_rate_i,
    input  logic [CHANNELS*RATE_WIDTH-1:0] low_rate_i,
    input  logic [CHANNELS*RATE_WIDTH-1:0] phase_offset_i,
    input  logic                           drift_en_i,
    input  logic                           drift_polarity_i,
    input  logic [RATE_WIDTH-1:0]          drift_interval_i,
    input  logic                           burst_mode_i,
    input  logic [BURST_WIDTH-1:0]         burst_length_i,
    output logic [CHANNELS-1:0]            clk_o,
    output logic [CHANNELS-1:0]            rising_o,
    output logic [CHANNELS-1:0]            falling_o,
    output logic [CHANNELS-1:0]            busy_o,
    output logic [CHANNELS-1:0]            done_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OFFSET = 3'd1,
        ST_HIGH   = 3'd2,
        ST_LOW    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic signed [RATE_WIDTH:0]   ACC_MAX  = $signed({1'b0, {RATE_WIDTH{1'b1}}});
    localparam logic signed [RATE_WIDTH:0]   ACC_MIN  = -ACC_MAX;
    localparam logic signed [RATE_WIDTH:0]   ACC_ONE  = $signed({{RATE_WIDTH{1'b0}}, 1'b1});
    localparam logic signed [RATE_WIDTH+1:0] SUM_MAX  = $signed({2'b00, {RATE_WIDTH{1'b1}}});
    localparam logic signed [RATE_WIDTH+1:0] SUM_ONE  = $signed({{(RATE_WIDTH+1){1'b0}}, 1'b1});
    localparam logic [RATE_WIDTH-1:0]        RATE_ONE = RATE_WIDTH'(1'b1);

    // Phase length in cycles: latched rate plus drift, clamped to [1, 2^W-1].
    function automatic logic [RATE_WIDTH-1:0] eff_rate(
        input logic [RATE_WIDTH-1:0]   rate,
        input logic signed [RATE_WIDTH:0] acc
    );
        logic signed [RATE_WIDTH+1:0] sum;
        sum = $signed({2'b00, rate}) + $signed({acc[RATE_WIDTH], acc});
        if (sum < SUM_ONE) begin
            return RATE_ONE;
        end else if (sum > SUM_MAX) begin
            return {RATE_WIDTH{1'b1}};
        end else begin
            return sum[RATE_WIDTH-1:0];
        end
    endfunction

    // One saturating drift step; the clamp keeps any phase reachable by eff_rate.
    function automatic logic signed [RATE_WIDTH:0] drift_step(
        input logic signed [RATE_WIDTH:0] acc,
        input logic                       up
    );
        if (up) begin
            return (acc < ACC_MAX) ? acc + ACC_ONE : acc;
        end else begin
            return (acc > ACC_MIN) ? acc - ACC_ONE : acc;
        end
    endfunction

    logic [1:0] rst_sync_r;
    logic       rst_int_n_s;

    // Reset synchroniser: asserts immediately, releases after two clock edges.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_sync_r[1];

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        state_t                   state_r, state_s;
        logic                     clk_r, clk_s;
        logic                     rise_r, rise_s;
        logic                     fall_r, fall_s;
        logic                     busy_r, busy_s;
        logic                     done_r, done_s;
        logic                     pol_r, pol_s;
        logic [RATE_WIDTH-1:0]    hi_rate_r, hi_rate_s;
        logic [RATE_WIDTH-1:0]    lo_rate_r, lo_rate_s;
        logic [RATE_WIDTH-1:0]    cnt_r, cnt_s;
        logic [RATE_WIDTH-1:0]    intv_r, intv_s;
        logic [BURST_WIDTH-1:0]   burst_len_r, burst_len_s;
        logic [BURST_WIDTH-1:0]   period_r, period_s;
        logic signed [RATE_WIDTH:0] drift_r, drift_s;
        logic                     run_s;
        logic                     burst_hit_s;
        logic                     drift_on_s;
        logic                     drift_tick_s;
        logic [RATE_WIDTH-1:0]    hi_in_s, lo_in_s, off_in_s;

        assign hi_in_s      = high_rate_i[ch*RATE_WIDTH +: RATE_WIDTH];
        assign lo_in_s      = low_rate_i[ch*RATE_WIDTH +: RATE_WIDTH];
        assign off_in_s     = phase_offset_i[ch*RATE_WIDTH +: RATE_WIDTH];
        assign run_s        = clk_en & generation_en_i[ch];
        assign burst_hit_s  = burst_mode_i && (burst_len_r != {BURST_WIDTH{1'b0}})
                              && (period_r >= burst_len_r);
        assign drift_on_s   = drift_en_i && (drift_interval_i != {RATE_WIDTH{1'b0}});
        assign drift_tick_s = drift_on_s
                              && (({1'b0, intv_r} + {{RATE_WIDTH{1'b0}}, 1'b1})
                                  >= {1'b0, drift_interval_i});

        // Next-state and next-output logic for one channel.
        always_comb begin
            state_s     = state_r;
            clk_s       = clk_r;
            pol_s       = pol_r;
            hi_rate_s   = hi_rate_r;
            lo_rate_s   = lo_rate_r;
            cnt_s       = cnt_r;
            intv_s      = intv_r;
            burst_len_s = burst_len_r;
            period_s    = period_r;
            drift_s     = drift_r;

            if (clk_en && init_i[ch]) begin
                pol_s       = starting_polarity_i[ch];
                hi_rate_s   = hi_in_s;
                lo_rate_s   = lo_in_s;
                burst_len_s = burst_length_i;
                drift_s     = {(RATE_WIDTH+1){1'b0}};
                period_s    = {BURST_WIDTH{1'b0}};
                intv_s      = {RATE_WIDTH{1'b0}};
                cnt_s       = off_in_s;
                clk_s       = ~starting_polarity_i[ch];
                state_s     = ST_OFFSET;
            end else if (run_s) begin
                case (state_r)
                    ST_IDLE: begin
                        state_s = ST_IDLE;
                    end
                    ST_OFFSET: begin
                        if (cnt_r != {RATE_WIDTH{1'b0}}) begin
                            cnt_s = cnt_r - RATE_ONE;
                        end else if (pol_r) begin
                            state_s  = ST_HIGH;
                            clk_s    = 1'b1;
                            cnt_s    = eff_rate(hi_rate_r, drift_r) - RATE_ONE;
                            period_s = (period_r == {BURST_WIDTH{1'b1}}) ? period_r
                                       : period_r + BURST_WIDTH'(1'b1);
                        end else begin
                            state_s = ST_LOW;
                            clk_s   = 1'b0;
                            cnt_s   = eff_rate(lo_rate_r, drift_r) - RATE_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (cnt_r != {RATE_WIDTH{1'b0}}) begin
                            cnt_s = cnt_r - RATE_ONE;
                        end else begin
                            state_s = ST_LOW;
                            clk_s   = 1'b0;
                            cnt_s   = eff_rate(lo_rate_r, drift_r) - RATE_ONE;
                        end
                    end
                    ST_LOW: begin
                        if (cnt_r != {RATE_WIDTH{1'b0}}) begin
                            cnt_s = cnt_r - RATE_ONE;
                        end else if (burst_hit_s) begin
                            state_s = ST_DONE;
                            clk_s   = ~pol_r;
                        end else begin
                            // A LOW->HIGH edge closes a full period; drift applies
                            // to the HIGH phase starting on the same edge.
                            state_s  = ST_HIGH;
                            clk_s    = 1'b1;
                            period_s = (period_r == {BURST_WIDTH{1'b1}}) ? period_r
                                       : period_r + BURST_WIDTH'(1'b1);
                            if (drift_tick_s) begin
                                intv_s  = {RATE_WIDTH{1'b0}};
                                drift_s = drift_step(drift_r, drift_polarity_i);
                            end else if (drift_on_s) begin
                                intv_s = intv_r + RATE_ONE;
                            end else begin
                                intv_s = intv_r;
                            end
                            cnt_s = eff_rate(hi_rate_r, drift_s) - RATE_ONE;
                        end
                    end
                    ST_DONE: begin
                        state_s = ST_DONE;
                    end
                    default: begin
                        state_s = ST_IDLE;
                        clk_s   = 1'b0;
                    end
                endcase
            end else begin
                state_s = state_r;
            end

            rise_s = clk_s & ~clk_r;
            fall_s = ~clk_s & clk_r;
            busy_s = (state_s == ST_OFFSET) || (state_s == ST_HIGH) || (state_s == ST_LOW);
            done_s = (state_s == ST_DONE);
        end

        // Channel state and registered outputs.
        always_ff @(posedge clk or negedge rst_int_n_s) begin
            if (!rst_int_n_s) begin
                state_r     <= ST_IDLE;
                clk_r       <= 1'b0;
                rise_r      <= 1'b0;
                fall_r      <= 1'b0;
                busy_r      <= 1'b0;
                done_r      <= 1'b0;
                pol_r       <= 1'b0;
                hi_rate_r   <= {RATE_WIDTH{1'b0}};
                lo_rate_r   <= {RATE_WIDTH{1'b0}};
                cnt_r       <= {RATE_WIDTH{1'b0}};
                intv_r      <= {RATE_WIDTH{1'b0}};
                burst_len_r <= {BURST_WIDTH{1'b0}};
                period_r    <= {BURST_WIDTH{1'b0}};
                drift_r     <= {(RATE_WIDTH+1){1'b0}};
            end else begin
                state_r     <= state_s;
                clk_r       <= clk_s;
                rise_r      <= rise_s;
                fall_r      <= fall_s;
                busy_r      <= busy_s;
                done_r      <= done_s;
                pol_r       <= pol_s;
                hi_rate_r   <= hi_rate_s;
                lo_rate_r   <= lo_rate_s;
                cnt_r       <= cnt_s;
                intv_r      <= intv_s;
                burst_len_r <= burst_len_s;
                period_r    <= period_s;
                drift_r     <= drift_s;
            end
        end

        assign clk_o[ch]     = clk_r;
        assign rising_o[ch]  = rise_r;
        assign falling_o[ch] = fall_r;
        assign busy_o[ch]    = busy_r;
        assign done_o[ch]    = done_r;
    end

endmodule

// File: tb/tb_multi_test_clk.sv
// Directed bench for multi_test_clk: waveform timing, burst, drift, freeze, reset.
module tb_multi_test_clk;

    localparam int CH = 2;
    localparam int RW = 8;
    localparam int BW = 16;

    logic              clk;
    logic              async_rst_n;
    logic              clk_en;
    logic [CH-1:0]     init_i;
    logic [CH-1:0]     starting_polarity_i;
    logic [CH-1:0]     generation_en_i;
    logic [CH*RW-1:0]  high_rate_i;
    logic [CH*RW-1:0]  low_rate_i;
    logic [CH*RW-1:0]  phase_offset_i;
    logic              drift_en_i;
    logic              drift_polarity_i;
    logic [RW-1:0]     drift_interval_i;
    logic              burst_mode_i;
    logic [BW-1:0]     burst_length_i;
    logic [CH-1:0]     clk_o;
    logic [CH-1:0]     rising_o;
    logic [CH-1:0]     falling_o;
    logic [CH-1:0]     busy_o;
    logic [CH-1:0]     done_o;

    int n_assert = 0;
    int n_fail   = 0;

    multi_test_clk #(.CHANNELS(CH), .RATE_WIDTH(RW), .BURST_WIDTH(BW)) dut (
        .clk                 (clk),
        .async_rst_n         (async_rst_n),
        .clk_en              (clk_en),
        .init_i              (init_i),
        .starting_polarity_i (starting_polarity_i),
        .generation_en_i     (generation_en_i),
        .high_rate_i         (high_rate_i),
        .low_rate_i          (low_rate_i),
        .phase_offset_i      (phase_offset_i),
        .drift_en_i          (drift_en_i),
        .drift_polarity_i    (drift_polarity_i),
        .drift_interval_i    (drift_interval_i),
        .burst_mode_i        (burst_mode_i),
        .burst_length_i      (burst_length_i),
        .clk_o               (clk_o),
        .rising_o            (rising_o),
        .falling_o           (falling_o),
        .busy_o              (busy_o),
        .done_o              (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_init(input logic [CH-1:0] m);
        init_i = m;
        tick();
        init_i = '0;
    endtask

    int rises;
    int done_at;
    int n;
    int rt [6];
    int exp_per [5];
    logic e_clk, e_r, e_f;

    initial begin
        async_rst_n         = 1'b1;
        clk_en              = 1'b0;
        init_i              = '0;
        starting_polarity_i = '0;
        generation_en_i     = '0;
        high_rate_i         = '0;
        low_rate_i          = '0;
        phase_offset_i      = '0;
        drift_en_i          = 1'b0;
        drift_polarity_i    = 1'b0;
        drift_interval_i    = '0;
        burst_mode_i        = 1'b0;
        burst_length_i      = '0;
        #2 async_rst_n = 1'b0;
        tick();
        tick();
        chk("rst_outs", {clk_o, rising_o, falling_o, busy_o, done_o}, 32'd0);
        async_rst_n = 1'b1;
        tick();
        tick();
        tick();

        // Complementary 4/4 clocks, offset 0
        clk_en              = 1'b1;
        generation_en_i     = 2'b11;
        starting_polarity_i = 2'b10;
        high_rate_i         = {8'd4, 8'd4};
        low_rate_i          = {8'd4, 8'd4};
        phase_offset_i      = {8'd0, 8'd0};
        pulse_init(2'b11);
        chk("a_offset_clk", clk_o, 32'h1);
        chk("a_busy", busy_o, 32'h3);
        tick();
        chk("a_exit_clk", clk_o, 32'h2);
        chk("a_exit_rise", rising_o, 32'h2);
        chk("a_exit_fall", falling_o, 32'h1);
        for (int k = 2; k <= 17; k++) begin
            tick();
            e_clk = ((k - 1) % 8) < 4;
            chk("a_clk", clk_o, {30'd0, e_clk, ~e_clk});
            chk("a_rise", rising_o, ((k - 1) % 8 == 0) ? 32'h2 : (((k - 1) % 8 == 4) ? 32'h1 : 32'h0));
        end

        // Offset 6, high 3 low 5, pol 1; mid-run rate change must be ignored
        generation_en_i     = 2'b01;
        starting_polarity_i = 2'b01;
        high_rate_i         = {8'd0, 8'd3};
        low_rate_i          = {8'd0, 8'd5};
        phase_offset_i      = {8'd0, 8'd6};
        pulse_init(2'b01);
        for (int k = 1; k <= 22; k++) begin
            tick();
            e_clk = (k >= 7) && (((k - 7) % 8) < 3);
            e_r   = (k >= 7) && (((k - 7) % 8) == 0);
            e_f   = (k >= 7) && (((k - 7) % 8) == 3);
            chk("b_wave", {clk_o[0], rising_o[0], falling_o[0]}, {29'd0, e_clk, e_r, e_f});
            if (k == 10) begin
                high_rate_i = {8'd0, 8'd9};
                low_rate_i  = {8'd0, 8'd1};
            end
        end

        // Burst of 3 periods, high=low=2
        high_rate_i    = {8'd0, 8'd2};
        low_rate_i     = {8'd0, 8'd2};
        phase_offset_i = {8'd0, 8'd0};
        burst_mode_i   = 1'b1;
        burst_length_i = 16'd3;
        pulse_init(2'b01);
        rises   = 0;
        done_at = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (rising_o[0]) rises++;
            if (done_o[0] && done_at == 0) done_at = k;
        end
        chk("c_rises", rises, 32'd3);
        chk("c_done_at", done_at, 32'd13);
        chk("c_done", done_o[0], 32'd1);
        chk("c_busy", busy_o[0], 32'd0);
        chk("c_clk", clk_o[0], 32'd0);
        burst_mode_i = 1'b0;

        // Lengthening drift every 2 completed periods
        high_rate_i      = {8'd0, 8'd4};
        low_rate_i       = {8'd0, 8'd4};
        drift_en_i       = 1'b1;
        drift_polarity_i = 1'b1;
        drift_interval_i = 8'd2;
        exp_per = '{8, 8, 10, 10, 12};
        rt = '{0, 0, 0, 0, 0, 0};
        n = 0;
        pulse_init(2'b01);
        for (int k = 1; k <= 55; k++) begin
            tick();
            if (rising_o[0] && n < 6) begin
                rt[n] = k;
                n++;
            end
        end
        chk("d_first_rise", rt[0], 32'd1);
        for (int i = 1; i < 6; i++) chk("d_period", rt[i] - rt[i-1], exp_per[i-1]);

        // Shortening drift at rate 1 clamps at period 2
        high_rate_i      = {8'd0, 8'd1};
        low_rate_i       = {8'd0, 8'd1};
        drift_polarity_i = 1'b0;
        drift_interval_i = 8'd1;
        rt = '{0, 0, 0, 0, 0, 0};
        n = 0;
        pulse_init(2'b01);
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (rising_o[0] && n < 6) begin
                rt[n] = k;
                n++;
            end
        end
        for (int i = 1; i < 6; i++) chk("d_clamp_period", rt[i] - rt[i-1], 32'd2);
        drift_en_i = 1'b0;

        // Freeze 5 cycles mid-HIGH
        high_rate_i = {8'd0, 8'd4};
        low_rate_i  = {8'd0, 8'd4};
        pulse_init(2'b01);
        tick();
        chk("e_enter_high", {clk_o[0], rising_o[0]}, 32'h3);
        tick();
        generation_en_i = 2'b00;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("e_frozen", {clk_o[0], rising_o[0], falling_o[0]}, 32'h4);
        end
        generation_en_i = 2'b01;
        tick();
        chk("e_high_8", {clk_o[0], falling_o[0]}, 32'h2);
        tick();
        chk("e_high_9", {clk_o[0], falling_o[0]}, 32'h2);
        tick();
        chk("e_fall_10", {clk_o[0], falling_o[0]}, 32'h1);
        tick();

        // Reset mid-LOW without a clock edge
        chk("f_pre_busy", busy_o, 32'h3);
        async_rst_n = 1'b0;
        #1;
        chk("f_outs", {clk_o, rising_o, falling_o, busy_o, done_o}, 32'd0);
        #3 async_rst_n = 1'b1;
        generation_en_i = 2'b11;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("f_idle", {clk_o, rising_o, busy_o}, 32'd0);
        end

        // Init held through reset release is only taken on the third edge
        async_rst_n = 1'b0;
        #2 async_rst_n = 1'b1;
        starting_polarity_i = 2'b01;
        init_i = 2'b01;
        tick();
        chk("g_edge1", busy_o[0], 32'd0);
        tick();
        chk("g_edge2", busy_o[0], 32'd0);
        tick();
        chk("g_edge3", busy_o[0], 32'd1);
        init_i = '0;

        // clk_en low holds the channel in OFFSET
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("h_hold", {busy_o[0], clk_o[0], rising_o[0]}, 32'h4);
        end
        clk_en = 1'b1;
        tick();
        chk("h_resume", {clk_o[0], rising_o[0]}, 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
